// File: rtl/regfile_streamer_pkg.sv
// regfile_streamer_pkg
// Shared definitions for the register-file read-out engine: FSM state
// encoding and the select code that parks bus A on its constant-zero input.
package regfile_streamer_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    SEL  = 3'd2,
    SEND = 3'd3,
    DONE = 3'd4
  } state_t;

  // Mux input 0 is tied to zero; driving it leaves bus A idle.
  localparam int unsigned SEL_IDLE = 0;

endpackage

// File: rtl/regfile_streamer_if.sv
// regfile_streamer_if
// Bundles the read-out engine's bus-A request/select, stream and status
// signals.
//   master : the streamer (drives sReq, sSelMux, sDataOut, sValid, sBusy,
//            sDone, sIndex; receives sStart, sGrant, sDataInBus, sReady)
//   slave  : controller / mux / downstream side (mirror directions)
interface regfile_streamer_if #(
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned SELECTION = 4
);
  logic                 sStart;
  logic                 sGrant;
  logic [DATAWIDTH-1:0] sDataInBus;
  logic                 sReq;
  logic [SELECTION-1:0] sSelMux;
  logic [DATAWIDTH-1:0] sDataOut;
  logic                 sValid;
  logic                 sReady;
  logic                 sBusy;
  logic                 sDone;
  logic [SELECTION-1:0] sIndex;

  modport master (
    input  sStart, sGrant, sDataInBus, sReady,
    output sReq, sSelMux, sDataOut, sValid, sBusy, sDone, sIndex
  );

  modport slave (
    output sStart, sGrant, sDataInBus, sReady,
    input  sReq, sSelMux, sDataOut, sValid, sBusy, sDone, sIndex
  );
endinterface

// File: rtl/regfile_streamer_outreg.sv
// stream_outreg
// One-entry holding register for a valid/ready stream. load_i captures
// data_i and raises valid_o; accept_i (a completed transfer) drops valid_o.
// Data is held unchanged until the next load.
//   clk, rst          clock, asynchronous active-high reset
//   load_i, data_i    capture request and data
//   accept_i          downstream accepted the current entry
//   data_o, valid_o   stream data and valid
module stream_outreg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             accept_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o
);
  logic [WIDTH-1:0] data_q;
  logic             valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      data_q  <= data_i;
      valid_q <= 1'b1;
    end else if (accept_i && valid_q) begin
      valid_q <= 1'b0;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
endmodule

// File: rtl/regfile_streamer.sv
// regfile_streamer
// Reading end of the register file. On sStart it requests bus A, walks
// select codes FIRSTSEL..FIRSTSEL+NUMREGS-1 one at a time, captures each
// register and emits it on a valid/ready stream, then pulses sDone.
//   clk, rst   clock, asynchronous active-high reset
//   bus        regfile_streamer_if.master (start, grant/request, mux select
//              and data, stream data/valid/ready, busy/done/index status)
module regfile_streamer
  import regfile_streamer_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned SELECTION = 4,
  parameter int unsigned FIRSTSEL  = 1,
  parameter int unsigned NUMREGS   = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_streamer_if.master   bus
);
  if (NUMREGS < 1 || (FIRSTSEL + NUMREGS - 1) > (2 ** SELECTION - 1)) begin : g_cfg_check
    $error("regfile_streamer: select range FIRSTSEL..FIRSTSEL+NUMREGS-1 does not fit SELECTION bits");
  end

  localparam logic [SELECTION-1:0] LAST_IDX  = SELECTION'(NUMREGS - 1);
  localparam logic [SELECTION-1:0] FIRST_SEL = SELECTION'(FIRSTSEL);
  localparam logic [SELECTION-1:0] IDLE_SEL  = SELECTION'(SEL_IDLE);

  state_t               state_q, state_d;
  logic [SELECTION-1:0] idx_q, idx_d;
  logic [SELECTION-1:0] sel_q, sel_d;
  logic                 req_q, req_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 load, accept;
  logic [DATAWIDTH-1:0] data_out;
  logic                 valid_out;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    load    = 1'b0;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: if (bus.sStart) begin
        state_d = REQ;
        idx_d   = '0;
      end
      REQ:  if (bus.sGrant) state_d = SEL;
      SEL:  if (bus.sGrant) begin
        load    = 1'b1;
        state_d = SEND;
      end else begin
        state_d = REQ;
      end
      SEND: if (valid_out && bus.sReady) begin
        accept = 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = REQ;
        end
      end
      DONE: begin
        state_d = IDLE;
        idx_d   = '0;
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase

    // All bus outputs are registered: decode them from the next state so
    // they line up with the state they belong to.
    req_d  = (state_d == REQ) || (state_d == SEL);
    sel_d  = (state_d == SEL) ? FIRST_SEL + idx_d : IDLE_SEL;
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      sel_q   <= '0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  stream_outreg #(.WIDTH(DATAWIDTH)) u_outreg (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load),
    .data_i   (bus.sDataInBus),
    .accept_i (accept),
    .data_o   (data_out),
    .valid_o  (valid_out)
  );

  assign bus.sReq     = req_q;
  assign bus.sSelMux  = sel_q;
  assign bus.sDataOut = data_out;
  assign bus.sValid   = valid_out;
  assign bus.sBusy    = busy_q;
  assign bus.sDone    = done_q;
  assign bus.sIndex   = idx_q;
endmodule

// File: tb/tb_regfile_streamer.sv
// tb_regfile_streamer
// Self-checking bench: a register-file mux model drives sDataInBus, and a
// transaction-level scoreboard (expected element order, busy window, one
// done pulse after the last transfer, stream hold rules) checks the DUT.
module tb_regfile_streamer;
  localparam int DW = 8;
  localparam int SW = 4;
  localparam int FS = 1;
  localparam int NR = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_streamer_if #(.DATAWIDTH(DW), .SELECTION(SW)) bus ();

  regfile_streamer #(
    .DATAWIDTH (DW),
    .SELECTION (SW),
    .FIRSTSEL  (FS),
    .NUMREGS   (NR)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [DW-1:0] regs [16];
  always_comb bus.sDataInBus = regs[bus.sSelMux];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // scoreboard state
  bit            busy_exp, done_exp, hold_exp, prev_valid, prev_take;
  int            xfer_cnt, run_xfers, run_dones, rc;
  logic [DW-1:0] prev_data;
  logic [SW-1:0] sel_log [32];
  bit            valid_log [32];
  bit            done_log [32];

  task automatic do_cycle(input bit st, input bit gr, input bit rd);
    bit next_done;
    @(negedge clk);
    bus.sStart = st;
    bus.sGrant = gr;
    bus.sReady = rd;
    #1;
    if (rc < 32) begin
      sel_log[rc]   = bus.sSelMux;
      valid_log[rc] = bus.sValid;
      done_log[rc]  = bus.sDone;
    end
    check("busy", bus.sBusy, busy_exp);
    check("done", bus.sDone, done_exp);
    check("req_with_valid", bus.sReq & bus.sValid, 0);
    if (bus.sValid) begin
      check("data", bus.sDataOut, regs[FS + xfer_cnt]);
      check("index", bus.sIndex, xfer_cnt);
    end
    if (hold_exp) begin
      check("hold_valid", bus.sValid, 1);
      check("hold_data", bus.sDataOut, prev_data);
    end
    if (bus.sSelMux != 0) check("selmux", bus.sSelMux, FS + xfer_cnt);
    if (bus.sValid && !prev_valid) check("capture_needs_grant", prev_take, 1);
    if (!busy_exp)
      check("idle_outputs", {bus.sReq, bus.sValid, bus.sSelMux, bus.sIndex, bus.sDone}, 0);

    next_done = 1'b0;
    if (bus.sValid && rd) begin
      xfer_cnt++;
      run_xfers++;
      if (xfer_cnt == NR) next_done = 1'b1;
    end
    if (done_exp) begin
      busy_exp = 1'b0;
      xfer_cnt = 0;
      run_dones++;
    end else if (!busy_exp && st) begin
      busy_exp = 1'b1;
      xfer_cnt = 0;
    end
    hold_exp   = bus.sValid && !rd;
    prev_data  = bus.sDataOut;
    prev_valid = bus.sValid;
    prev_take  = (bus.sSelMux != 0) && gr;
    done_exp   = next_done;
    rc++;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.sStart = 1'b0;
    bus.sGrant = 1'b0;
    bus.sReady = 1'b0;
    @(negedge clk);
    #1;
    check("rst_valid", bus.sValid, 0);
    check("rst_req", bus.sReq, 0);
    check("rst_selmux", bus.sSelMux, 0);
    check("rst_busy", bus.sBusy, 0);
    check("rst_done", bus.sDone, 0);
    check("rst_index", bus.sIndex, 0);
    check("rst_data", bus.sDataOut, 0);
    rst = 1'b0;
    busy_exp = 0; done_exp = 0; hold_exp = 0;
    prev_valid = 0; prev_take = 0; xfer_cnt = 0;
  endtask

  // mode 0 full rate, 1 backpressure, 2 grant loss, 3 start while busy, 4 random
  task automatic run_readout(input int mode, input string name);
    int c;
    bit st, gr, rd;
    run_xfers = 0;
    run_dones = 0;
    rc = 0;
    c  = 0;
    while (c < 300 && (c < 22 || busy_exp)) begin
      st = (c == 0);
      gr = 1'b1;
      rd = 1'b1;
      case (mode)
        1: rd = !(c >= 3 && c <= 6);
        2: gr = (c != 8);
        3: st = (c == 0) || (c == 7);
        4: begin
          st = (c == 0) || (c >= 1 && c <= 15 && $urandom_range(0, 7) == 0);
          gr = ($urandom_range(0, 3) != 0);
          rd = $urandom_range(0, 1) == 1;
        end
        default: ;
      endcase
      do_cycle(st, gr, rd);
      if (mode == 1 && c >= 3 && c <= 6) begin
        check("bp_valid", bus.sValid, 1);
        check("bp_data", bus.sDataOut, regs[FS]);
        check("bp_req", bus.sReq, 0);
      end
      if (mode == 2 && c == 9) begin
        check("gl_req", bus.sReq, 1);
        check("gl_selmux", bus.sSelMux, 0);
        check("gl_valid", bus.sValid, 0);
      end
      c++;
    end
    check({name, "_finished"}, busy_exp, 0);
    check({name, "_xfers"}, run_xfers, NR);
    check({name, "_dones"}, run_dones, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = '0;
    regs[1] = 8'd1; regs[2] = 8'd3; regs[3] = 8'd4; regs[4] = 8'd5; regs[5] = 8'd8;
    rst = 1'b1;
    bus.sStart = 1'b0;
    bus.sGrant = 1'b0;
    bus.sReady = 1'b0;
    apply_reset();

    // full read-out timing: SEL on cycles 2,5,..,14, valid on 3,6,..,15, done on 16
    run_readout(0, "full");
    for (int c = 1; c <= 20; c++) begin
      check("full_sel_seq", sel_log[c], (c % 3 == 2 && c <= 14) ? FS + c / 3 : 0);
      check("full_valid_seq", valid_log[c], (c % 3 == 0 && c <= 15) ? 1 : 0);
      check("full_done_seq", done_log[c], (c == 16) ? 1 : 0);
    end

    run_readout(1, "backpressure");
    run_readout(2, "grant_loss");
    run_readout(3, "start_busy");

    // grant never given
    rc = 0;
    do_cycle(1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= 20; c++) begin
      do_cycle(1'b0, 1'b0, 1'b0);
      check("ng_req", bus.sReq, 1);
      check("ng_selmux", bus.sSelMux, 0);
      check("ng_valid", bus.sValid, 0);
    end
    apply_reset();

    // reset while an element waits in SEND
    rc = 0;
    do_cycle(1'b1, 1'b1, 1'b0);
    for (int c = 1; c <= 3; c++) do_cycle(1'b0, 1'b1, 1'b0);
    check("pre_rst_valid", bus.sValid, 1);
    apply_reset();

    // randomized contents and handshakes; first run also proves restart from index 0
    for (int r = 0; r < 6; r++) begin
      for (int i = FS; i < FS + NR; i++) regs[i] = DW'($urandom);
      run_readout(4, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
